alu_share_ctrl: RTL and testbench

//  Round-robin controller that shares one 16-bit, 16-mode alu instance among NREQ requesters.
//  Per-requester valid/ready handshake; one response port with valid/ready handshake.

---
 rtl/alu_share_ctrl_if.sv | 37 +++
 rtl/alu_share_ctrl.sv | 103 ++++++++++
 tb/tb_alu_share_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// Bundle of request, alu and response signals between the requesters, the
// shared alu and the sharing controller.
interface alu_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int RW   = 32,
  parameter int MW   = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ*MW-1:0] req_mode;
  logic [DW-1:0]      alu_a;
  logic [DW-1:0]      alu_b;
  logic [MW-1:0]      alu_mode;
  logic [RW-1:0]      alu_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [RW-1:0]      rsp_y;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_err;
  logic               busy;

  // Environment side: requesters, alu result and response consumer.
  modport master (
    output req_valid, req_a, req_b, req_mode, alu_y, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_mode, rsp_valid, rsp_y, rsp_id, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mode, alu_y, rsp_ready,
    output req_ready, alu_a, alu_b, alu_mode, rsp_valid, rsp_y, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational alu among NREQ requesters,
// one op in flight, with divide/modulo-by-zero trapping.
//
// state | meaning
// IDLE  | arbitrate; on grant latch operands and requester id
// EXEC  | alu settles on registered operands; capture result or trap
// RESP  | hold response until rsp_ready
module alu_share_ctrl #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int RW   = 32,
  parameter int MW   = 4
) (
  input  logic           clock,
  input  logic           reset,
  alu_share_ctrl_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic           win_vld;
  logic           div_zero;

  // Scan from farthest to nearest so the requester closest after ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  assign div_zero = ((bus.alu_mode == MW'(4)) || (bus.alu_mode == MW'(5))) &&
                    (bus.alu_b == '0);

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = EXEC;
          // Grant is suppressed while reset is asserted.
          if (reset) bus.req_ready[win] = 1'b1;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr           <= IDW'(NREQ - 1);
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_mode  <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            bus.alu_a    <= bus.req_a[int'(win)*DW +: DW];
            bus.alu_b    <= bus.req_b[int'(win)*DW +: DW];
            bus.alu_mode <= bus.req_mode[int'(win)*MW +: MW];
            bus.rsp_id   <= win;
            ptr          <= win;
          end
        end
        EXEC: begin
          bus.rsp_y     <= div_zero ? RW'(0) : bus.alu_y;
          bus.rsp_err   <= div_zero;
          bus.rsp_valid <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a small behavioural alu.
module tb_alu_share_ctrl;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  alu_share_ctrl_if #(.NREQ(4), .DW(16), .RW(32), .MW(4)) bus ();

  alu_share_ctrl #(.NREQ(4), .DW(16), .RW(32), .MW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divide/modulo by zero return a marker so a missing trap shows up.
  always_comb begin
    case (bus.alu_mode)
      4'd0:    bus.alu_y = 32'(bus.alu_a) + 32'(bus.alu_b);
      4'd1:    bus.alu_y = 32'(bus.alu_a) - 32'(bus.alu_b);
      4'd2:    bus.alu_y = 32'(bus.alu_a & bus.alu_b);
      4'd3:    bus.alu_y = 32'(bus.alu_a) * 32'(bus.alu_b);
      4'd4:    bus.alu_y = (bus.alu_b == 16'd0) ? 32'hDEAD_BEEF : 32'(bus.alu_a / bus.alu_b);
      4'd5:    bus.alu_y = (bus.alu_b == 16'd0) ? 32'hDEAD_BEEF : 32'(bus.alu_a % bus.alu_b);
      default: bus.alu_y = 32'(bus.alu_a ^ bus.alu_b);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] mode);
    bus.req_a[id*16 +: 16]  = a;
    bus.req_b[id*16 +: 16]  = b;
    bus.req_mode[id*4 +: 4] = mode;
  endtask

  // Single-requester op with rsp_ready already high: grant, exec, resp, idle.
  task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] mode, input logic [31:0] ey, input logic ee);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    set_req(id, a, b, mode);
    bus.req_valid = oh;
    bus.rsp_ready = 1'b1;
    #1;
    chk("op_grant", 32'(bus.req_ready), 32'(oh));
    step();
    bus.req_valid = '0;
    chk("op_exec_busy", 32'(bus.busy), 32'd1);
    chk("op_exec_rdy", 32'(bus.req_ready), 32'd0);
    chk("op_alu_a", 32'(bus.alu_a), 32'(a));
    chk("op_exec_novalid", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("op_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("op_rsp_y", bus.rsp_y, ey);
    chk("op_rsp_id", 32'(bus.rsp_id), 32'(id));
    chk("op_rsp_err", 32'(bus.rsp_err), 32'(ee));
    step();
    chk("op_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("op_done_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_mode  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 16'(i + 10), 16'd3, 4'd0);

    // T1: reset held with all requesters valid
    repeat (3) step();
    chk("t1_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_alu_a", 32'(bus.alu_a), 32'd0);
    chk("t1_alu_b", 32'(bus.alu_b), 32'd0);
    chk("t1_alu_mode", 32'(bus.alu_mode), 32'd0);
    chk("t1_rsp_y", bus.rsp_y, 32'd0);
    chk("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("t1_rsp_err", 32'(bus.rsp_err), 32'd0);
    bus.req_valid = '0;
    reset = 1'b1;
    step();

    // T2: 3*5 from requester 0
    do_op(0, 16'd3, 16'd5, 4'd3, 32'd15, 1'b0);

    // T3: fresh pointer, all valid -> 0,1,2,3,0
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 16'(i + 1), 16'd2, 4'd0);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("t3_grant", 32'(bus.req_ready), 32'(4'b0001 << (n % 4)));
      step();
      chk("t3_exec_rdy", 32'(bus.req_ready), 32'd0);
      step();
      chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t3_rsp_id", 32'(bus.rsp_id), 32'(n % 4));
      chk("t3_rsp_y", bus.rsp_y, 32'((n % 4) + 3));
      chk("t3_resp_rdy", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.req_valid = '0;

    // T4: divide by zero trapped, then a legal modulo
    do_op(2, 16'd7, 16'd0, 4'd4, 32'd0, 1'b1);
    do_op(2, 16'd17, 16'd5, 4'd5, 32'd2, 1'b0);

    // T5: back-pressure on the response; pointer now 2
    bus.rsp_ready = 1'b0;
    set_req(1, 16'd9, 16'd4, 4'd0);
    set_req(3, 16'd20, 16'd3, 4'd3);
    bus.req_valid = 4'b0010;
    #1;
    chk("t5_grant1", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = 4'b1001;
    step();
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t5_rsp_y", bus.rsp_y, 32'd13);
    chk("t5_rsp_id", 32'(bus.rsp_id), 32'd1);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t5_hold_y", bus.rsp_y, 32'd13);
      chk("t5_hold_rdy", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("t5_release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_next_grant", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid = '0;
    step();
    chk("t5_req3_y", bus.rsp_y, 32'd60);
    chk("t5_req3_id", 32'(bus.rsp_id), 32'd3);
    step();

    // T6: reset during EXEC, pointer set to 1 first
    do_op(1, 16'd100, 16'd1, 4'd1, 32'd99, 1'b0);
    bus.req_valid = 4'b1111;
    #1;
    chk("t6_grant2", 32'(bus.req_ready), 32'b0100);
    step();
    chk("t6_exec_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_rdy", 32'(bus.req_ready), 32'd0);
    chk("t6_rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    bus.req_valid = '0;
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("t6_grant0", 32'(bus.req_ready), 32'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
